// File: rtl/fc_err_receiver.sv
// fc_err_receiver
// Receiving end of the FC error-propagation interface. Collects one
// mini-batch of FC error words, applies the ReLU derivative using activation
// signs snooped from the FC input write bus, then streams the masked errors to
// the conv back-propagation stage one beat per valid/ready handshake.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   we, addr, data             FC write bus (snooped only)
//   fc1_com_end, fc2_com_end   FC bank select; both low = FC input layer writes
//   bck_prop_start             level, high for the whole back-prop of a batch
//   fc_err_valid/prop/addr     one-cycle strobe carrying an error word and cell
//   fc_bck_prop_end            level, FC memory finished emitting errors
//   err_out_valid/ready/data/addr  masked error stream, cells 0..FRT_CELL-1
//   conv_err_done              one-cycle pulse after the last beat is accepted
//   err_missing, err_addr_oob  sticky per-batch error flags
module fc_err_receiver #(
    parameter int FRT_CELL = 32,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              fc1_com_end,
    input  logic              fc2_com_end,
    input  logic              bck_prop_start,
    input  logic              fc_err_valid,
    input  logic [DATA_W-1:0] fc_err_prop,
    input  logic [ADDR_W-1:0] fc_err_addr,
    input  logic              fc_bck_prop_end,
    output logic              err_out_valid,
    input  logic              err_out_ready,
    output logic [DATA_W-1:0] err_out_data,
    output logic [ADDR_W-1:0] err_out_addr,
    output logic              conv_err_done,
    output logic              err_missing,
    output logic              err_addr_oob
);

    localparam int IDX_W = (FRT_CELL > 1) ? $clog2(FRT_CELL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRT_CELL - 1);

    typedef enum logic [2:0] {IDLE, COLLECT, CHECK, STREAM, DONE} state_t;

    state_t              state;
    logic [FRT_CELL-1:0] act_pos;
    logic [FRT_CELL-1:0] rx;
    logic [DATA_W-1:0]   err_buf [FRT_CELL];
    logic [IDX_W-1:0]    idx;
    logic                start_q;

    logic             start_rise;
    logic             snoop_hit;
    logic             err_in_range;
    logic [IDX_W-1:0] snoop_idx;
    logic [IDX_W-1:0] err_idx;
    logic [IDX_W-1:0] idx_nxt;

    assign start_rise   = bck_prop_start && !start_q;
    assign snoop_hit    = we && !fc1_com_end && !fc2_com_end && (addr < ADDR_W'(FRT_CELL));
    assign err_in_range = fc_err_addr < ADDR_W'(FRT_CELL);
    assign snoop_idx    = addr[IDX_W-1:0];
    assign err_idx      = fc_err_addr[IDX_W-1:0];
    assign idx_nxt      = idx + IDX_W'(1);

    // Activation sign bitmap: 1 where the forward activation was strictly
    // positive, i.e. where the ReLU derivative is 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            act_pos <= '0;
        else if (snoop_hit)
            act_pos[snoop_idx] <= !data[DATA_W-1] && (|data);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rx            <= '0;
            idx           <= '0;
            // Treat a start level already high out of reset as "not a new
            // edge": a batch interrupted by reset must not self-restart.
            start_q       <= 1'b1;
            err_out_valid <= 1'b0;
            err_out_data  <= '0;
            err_out_addr  <= '0;
            conv_err_done <= 1'b0;
            err_missing   <= 1'b0;
            err_addr_oob  <= 1'b0;
            for (int i = 0; i < FRT_CELL; i++) err_buf[i] <= '0;
        end else begin
            start_q       <= bck_prop_start;
            conv_err_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        state        <= COLLECT;
                        rx           <= '0;
                        err_missing  <= 1'b0;
                        err_addr_oob <= 1'b0;
                        // Cleared buffer makes unreceived cells stream as 0.
                        for (int i = 0; i < FRT_CELL; i++) err_buf[i] <= '0;
                    end
                end
                COLLECT: begin
                    if (!bck_prop_start) begin
                        state <= IDLE;
                    end else begin
                        if (fc_err_valid) begin
                            if (err_in_range) begin
                                err_buf[err_idx] <= act_pos[err_idx] ? fc_err_prop : '0;
                                rx[err_idx]      <= 1'b1;
                            end else begin
                                err_addr_oob <= 1'b1;
                            end
                        end
                        if (fc_bck_prop_end) state <= CHECK;
                    end
                end
                CHECK: begin
                    if (!bck_prop_start) begin
                        state <= IDLE;
                    end else begin
                        err_missing   <= ~&rx;
                        idx           <= '0;
                        err_out_valid <= 1'b1;
                        err_out_data  <= err_buf[0];
                        err_out_addr  <= '0;
                        state         <= STREAM;
                    end
                end
                STREAM: begin
                    if (!bck_prop_start) begin
                        state         <= IDLE;
                        err_out_valid <= 1'b0;
                    end else if (err_out_ready) begin
                        if (idx == LAST_IDX) begin
                            state         <= DONE;
                            err_out_valid <= 1'b0;
                            conv_err_done <= 1'b1;
                        end else begin
                            idx          <= idx_nxt;
                            err_out_data <= err_buf[idx_nxt];
                            err_out_addr <= ADDR_W'(idx_nxt);
                        end
                    end
                end
                DONE: begin
                    // conv_err_done was raised on entry; it drops here.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_err_receiver.sv
module tb_fc_err_receiver;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
    logic        fc1_com_end;
    logic        fc2_com_end;
    logic        bck_prop_start;
    logic        fc_err_valid;
    logic [15:0] fc_err_prop;
    logic [15:0] fc_err_addr;
    logic        fc_bck_prop_end;
    logic        err_out_valid;
    logic        err_out_ready;
    logic [15:0] err_out_data;
    logic [15:0] err_out_addr;
    logic        conv_err_done;
    logic        err_missing;
    logic        err_addr_oob;

    fc_err_receiver #(.FRT_CELL(32), .DATA_W(16), .ADDR_W(16)) dut (
        .clk(clk), .reset(reset), .we(we), .addr(addr), .data(data),
        .fc1_com_end(fc1_com_end), .fc2_com_end(fc2_com_end),
        .bck_prop_start(bck_prop_start), .fc_err_valid(fc_err_valid),
        .fc_err_prop(fc_err_prop), .fc_err_addr(fc_err_addr),
        .fc_bck_prop_end(fc_bck_prop_end), .err_out_valid(err_out_valid),
        .err_out_ready(err_out_ready), .err_out_data(err_out_data),
        .err_out_addr(err_out_addr), .conv_err_done(conv_err_done),
        .err_missing(err_missing), .err_addr_oob(err_addr_oob)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: what the stream must contain, derived from the rules.
    bit          act_m [32];
    logic [15:0] exp_data [32];
    logic [15:0] obs [32];
    bit          exp_miss, exp_oob;
    int          exp_idx, beats, strm_cycles, dones;
    int          q_addr [$];
    logic [15:0] q_dat [$];

    // Compare-process history
    bit          prev_hs31, prev_hold;
    logic [15:0] prev_data, prev_addr;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle checks of the stream against the model.
    always @(negedge clk) begin
        if (reset) begin
            prev_hs31 = 1'b0;
            prev_hold = 1'b0;
        end else begin
            chk("done_pulse", conv_err_done, prev_hs31);
            if (conv_err_done) dones++;
            if (prev_hold) begin
                chk("hold_valid", err_out_valid, 1'b1);
                chk("hold_data", err_out_data, prev_data);
                chk("hold_addr", err_out_addr, prev_addr);
            end
            if (err_out_valid) begin
                strm_cycles++;
                chk("beat_addr", err_out_addr, exp_idx);
                chk("beat_data", err_out_data, exp_data[exp_idx[4:0]]);
                obs[err_out_addr[4:0]] = err_out_data;
                if (err_out_ready && bck_prop_start) begin
                    beats++;
                    exp_idx++;
                end
            end
            prev_hs31 = err_out_valid && err_out_ready && bck_prop_start && (err_out_addr == 16'd31);
            prev_hold = err_out_valid && !err_out_ready && bck_prop_start;
            prev_data = err_out_data;
            prev_addr = err_out_addr;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic snoop(int a, logic [15:0] d, bit f1, bit f2);
        we = 1'b1; addr = 16'(a); data = d; fc1_com_end = f1; fc2_com_end = f2;
        tick;
        we = 1'b0; fc1_com_end = 1'b0; fc2_com_end = 1'b0;
        if (!f1 && !f2 && a < 32) act_m[a] = ($signed(d) > 0);
    endtask

    task automatic push(int a, logic [15:0] d);
        q_addr.push_back(a);
        q_dat.push_back(d);
    endtask

    // Model of one batch: last write wins, masked by activation sign,
    // unreceived cells are zero.
    task automatic build_model;
        bit got [32];
        for (int i = 0; i < 32; i++) begin exp_data[i] = 16'h0; got[i] = 1'b0; obs[i] = 16'hxxxx; end
        exp_oob = 1'b0;
        foreach (q_addr[k]) begin
            if (q_addr[k] < 32) begin
                exp_data[q_addr[k]] = act_m[q_addr[k]] ? q_dat[k] : 16'h0;
                got[q_addr[k]] = 1'b1;
            end else exp_oob = 1'b1;
        end
        exp_miss = 1'b0;
        for (int i = 0; i < 32; i++) if (!got[i]) exp_miss = 1'b1;
    endtask

    task automatic launch;
        build_model;
        bck_prop_start = 1'b0;
        tick;
        bck_prop_start = 1'b1;
        exp_idx = 0; beats = 0; strm_cycles = 0;
        tick;
    endtask

    task automatic send_errs;
        foreach (q_addr[k]) begin
            fc_err_valid = 1'b1; fc_err_addr = 16'(q_addr[k]); fc_err_prop = q_dat[k];
            tick;
        end
        fc_err_valid = 1'b0;
        fc_bck_prop_end = 1'b1;
        tick;
        fc_bck_prop_end = 1'b0;
        chk("latency_check_cycle", err_out_valid, 1'b0);
        tick;
        chk("latency_first_valid", err_out_valid, 1'b1);
    endtask

    task automatic wait_done(bit toggle, int bound);
        int d0 = dones;
        int n = 0;
        while (dones == d0 && n < bound) begin
            tick;
            if (toggle) err_out_ready = ~err_out_ready;
            n++;
        end
        if (dones == d0) chk("done_timeout", 0, 1);
        err_out_ready = 1'b1;
    endtask

    task automatic base_errs;
        q_addr.delete(); q_dat.delete();
        for (int i = 0; i < 32; i++) push(i, 16'h0100);
    endtask

    task automatic end_checks(int exp_cycles);
        chk("beats", beats, 32);
        chk("stream_cycles", strm_cycles, exp_cycles);
        chk("err_missing", err_missing, exp_miss);
        chk("err_addr_oob", err_addr_oob, exp_oob);
    endtask

    initial begin
        bit seen;
        int d0;
        reset = 1'b1; we = 0; addr = 0; data = 0; fc1_com_end = 0; fc2_com_end = 0;
        bck_prop_start = 0; fc_err_valid = 0; fc_err_prop = 0; fc_err_addr = 0;
        fc_bck_prop_end = 0; err_out_ready = 1'b1;
        for (int i = 0; i < 32; i++) act_m[i] = 1'b0;
        repeat (3) tick;
        chk("rst_valid", err_out_valid, 0);
        chk("rst_done", conv_err_done, 0);
        chk("rst_data", err_out_data, 0);
        chk("rst_addr", err_out_addr, 0);
        chk("rst_flags", {err_missing, err_addr_oob}, 0);
        reset = 1'b0;
        tick;

        // 1: alternating activations, full throughput
        for (int i = 0; i < 32; i++) snoop(i, (i % 2 == 0) ? 16'h0001 : 16'hFFFF, 0, 0);
        base_errs;
        launch; send_errs; wait_done(0, 200);
        end_checks(32);
        chk("t1_obs0", obs[0], 16'h0100);
        chk("t1_obs1", obs[1], 16'h0000);
        chk("t1_obs30", obs[30], 16'h0100);

        // 2: ready toggling, first valid cycle not ready
        base_errs;
        launch; err_out_ready = 1'b0; send_errs; wait_done(1, 300);
        end_checks(64);

        // 3: cell 31 never sent
        q_addr.delete(); q_dat.delete();
        for (int i = 0; i < 31; i++) push(i, 16'h0100);
        launch; send_errs; wait_done(0, 200);
        end_checks(32);
        chk("t3_obs31", obs[31], 16'h0000);
        chk("t3_missing_lit", err_missing, 1);

        // 4: out-of-range address, duplicate, negative error, ignored snoops
        snoop(5, 16'h0003, 0, 0);
        snoop(7, 16'h0001, 1, 0);
        snoop(9, 16'h0001, 0, 1);
        snoop(40, 16'h0001, 0, 0);
        q_addr.delete(); q_dat.delete();
        for (int i = 0; i < 32; i++) push(i, (i == 5) ? 16'h0011 : (i == 2) ? 16'hFF00 : 16'h0100);
        push(40, 16'h0777);
        push(5, 16'h0022);
        launch; send_errs; wait_done(0, 200);
        end_checks(32);
        chk("t4_obs5", obs[5], 16'h0022);
        chk("t4_obs2", obs[2], 16'hFF00);
        chk("t4_obs7", obs[7], 16'h0000);
        chk("t4_obs9", obs[9], 16'h0000);
        chk("t4_oob_lit", err_addr_oob, 1);

        // 5: abort at beat 10, then a clean batch
        base_errs;
        launch; send_errs;
        begin
            int n = 0;
            while (beats < 10 && n < 100) begin tick; n++; end
        end
        chk("t5_at_beat10", err_out_addr, 10);
        d0 = dones;
        bck_prop_start = 1'b0; err_out_ready = 1'b0;
        tick;
        chk("t5_abort_valid", err_out_valid, 0);
        repeat (5) tick;
        chk("t5_no_done", dones, d0);
        err_out_ready = 1'b1;
        base_errs;
        launch; send_errs; wait_done(0, 200);
        end_checks(32);

        // 6: reset during COLLECT with start held high
        q_addr.delete(); q_dat.delete();
        push(40, 16'h0001);
        launch;
        fc_err_valid = 1'b1; fc_err_addr = 16'd40; fc_err_prop = 16'h0001;
        tick;
        fc_err_valid = 1'b0;
        chk("t6_oob_before", err_addr_oob, 1);
        reset = 1'b1;
        #2;
        chk("t6_rst_outputs", {err_out_valid, conv_err_done, err_missing, err_addr_oob}, 0);
        tick;
        reset = 1'b0;
        for (int i = 0; i < 32; i++) act_m[i] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 32; i++) begin
            fc_err_valid = 1'b1; fc_err_addr = 16'(i); fc_err_prop = 16'h0100;
            tick;
        end
        fc_err_valid = 1'b0; fc_bck_prop_end = 1'b1;
        tick;
        fc_bck_prop_end = 1'b0;
        repeat (40) begin tick; if (err_out_valid) seen = 1'b1; end
        chk("t6_stays_idle", seen, 0);
        // act bitmap was cleared by reset: everything masks to zero
        base_errs;
        launch; send_errs; wait_done(0, 200);
        end_checks(32);
        chk("t6_obs0", obs[0], 16'h0000);

        bck_prop_start = 1'b0;
        repeat (3) tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
